// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: func3 access codes and FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store strobes/replication, load extension,
// and illegal/misaligned access detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [31:0] w_byte_shift;
  logic [31:0] w_half_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_shift = i_rdata >> {i_addr, 3'b000};
  assign w_half_shift = i_rdata >> {i_addr[1], 4'b0000};
  assign w_byte       = w_byte_shift[7:0];
  assign w_half       = w_half_shift[15:0];

  always_comb begin
    o_err   = 1'b0;
    o_wstrb = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = 32'd0;
    case (i_op)
      MEM_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_wstrb = i_we ? (4'b0001 << i_addr) : 4'b0000;
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      MEM_H: begin
        o_err   = i_addr[0];
        o_wdata = {2{i_wdata[15:0]}};
        o_wstrb = i_we ? (4'b0011 << {i_addr[1], 1'b0}) : 4'b0000;
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      MEM_W: begin
        o_err   = (i_addr != 2'b00);
        o_wstrb = i_we ? 4'b1111 : 4'b0000;
        o_rdata = i_rdata;
      end
      // Unsigned variants exist only for loads.
      MEM_BU: begin
        o_err   = i_we;
        o_rdata = {24'd0, w_byte};
      end
      MEM_HU: begin
        o_err   = i_we | i_addr[0];
        o_rdata = {16'd0, w_half};
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one execute-stage request, runs a single-outstanding
// bus transaction and returns formatted load data or an error.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rdata
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_next;
  logic [2:0]        r_op;
  logic              r_we;
  logic [1:0]        r_addr_lo;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_wstrb;
  logic [DATA_W-1:0] r_bus_wdata;

  logic              w_accept;
  logic              w_idle;
  logic [2:0]        w_al_op;
  logic              w_al_we;
  logic [1:0]        w_al_addr;
  logic [3:0]        w_al_wstrb;
  logic [DATA_W-1:0] w_al_wdata;
  logic [DATA_W-1:0] w_al_rdata;
  logic              w_al_err;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = req_valid & req_ready;

  // One aligner serves both phases: live request fields while idle, latched ones afterwards.
  assign w_al_op   = w_idle ? req_op        : r_op;
  assign w_al_we   = w_idle ? req_we        : r_we;
  assign w_al_addr = w_idle ? req_addr[1:0] : r_addr_lo;

  lsu_align u_align (
    .i_op    (w_al_op),
    .i_we    (w_al_we),
    .i_addr  (w_al_addr),
    .i_wdata (req_wdata),
    .i_rdata (bus_rdata),
    .o_wstrb (w_al_wstrb),
    .o_wdata (w_al_wdata),
    .o_rdata (w_al_rdata),
    .o_err   (w_al_err)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept)      w_state_next = w_al_err ? RESP : BUS;
      BUS:  if (bus_req_ready) w_state_next = WAIT;
      WAIT: if (bus_rsp_valid) w_state_next = RESP;
      RESP:                    w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = w_idle & ~rst;
    bus_req_valid = (r_state == BUS);
    resp_valid    = (r_state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= 3'd0;
      r_we        <= 1'b0;
      r_addr_lo   <= 2'd0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wstrb <= 4'b0000;
      r_bus_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_op      <= req_op;
        r_we      <= req_we;
        r_addr_lo <= req_addr[1:0];
        r_err     <= w_al_err;
        r_rdata   <= '0;
        if (!w_al_err) begin
          r_bus_we    <= req_we;
          r_bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
          r_bus_wstrb <= w_al_wstrb;
          r_bus_wdata <= w_al_wdata;
        end
      end
      if (r_state == WAIT && bus_rsp_valid) begin
        r_rdata <= r_we ? '0 : w_al_rdata;
      end
    end
  end

  assign resp_err   = r_err & resp_valid;
  assign resp_rdata = r_rdata;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wstrb  = r_bus_wstrb;
  assign bus_wdata  = r_bus_wdata;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit that executes the memory access described by the decoder's mem_w/mem_op outputs against a word-addressed data bus.
- Accepts one request per transaction from the execute stage over a valid/ready handshake.
- Drives a single-outstanding request/response bus, applies byte-lane alignment and write strobes, and returns sign- or zero-extended load data.
- Sits between the execute stage (ALU address, rs2 data) and data memory.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; fixed at 32, so four byte lanes.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load (decoder mem_w).
- req_op  in  3  access type (decoder mem_op = func3).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse: transaction finished.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal op; valid with resp_valid.
- bus_req_valid  out  1  bus request.
- bus_req_ready  in  1  bus accepts request.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  word address, bits [1:0] = 0.
- bus_wstrb  out  4  byte enables; 0000 for reads.
- bus_wdata  out  32  lane-replicated store data.
- bus_rsp_valid  in  1  read data or write ack.
- bus_rdata  in  32  read word.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - req_ready = 0 while rst is high.
  - resp_valid, resp_err, bus_req_valid, bus_we = 0.
  - resp_rdata, bus_addr, bus_wdata = 0; bus_wstrb = 0000.
  - Reset mid-transaction aborts it with no resp_valid. A bus response arriving after the reset is ignored.
- req_op encoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal, including 100/101 with req_we=1.
- Misalignment: half access with addr[0]=1; word access with addr[1:0]≠00.
- States are IDLE, BUS, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - A handshake (req_valid & req_ready) latches op, we, addr, and wdata.
  - Illegal or misaligned request: go to RESP with err=1. No bus activity.
  - Legal request: go to BUS. bus_* outputs are registered from the latched request.
- BUS:
  - bus_req_valid = 1, held stable until bus_req_ready.
  - On the bus handshake, go to WAIT; bus_req_valid drops the next cycle.
- WAIT:
  - Go to RESP on bus_rsp_valid.
  - bus_rsp_valid is ignored in every other state, so a same-cycle response during BUS is not supported.
- RESP:
  - resp_valid = 1 for exactly one cycle, with resp_err as determined.
  - Return to IDLE. req_ready rises in the next cycle, so there is no back-to-back accept.
- Minimum latency:
  - Legal access with zero wait states: accept at T, bus_req_valid at T+1, rsp at T+2, resp_valid at T+3.
  - Error case: resp_valid at T+1.
- Store formatting:
  - SB: wdata = {4{d[7:0]}}, wstrb = 0001<<addr[1:0].
  - SH: wdata = {2{d[15:0]}}, wstrb = 0011<<{addr[1],1'b0}.
  - SW: wdata = d, wstrb = 1111.
- Load formatting:
  - The lane is selected by latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- bus_addr = {addr[ADDR_W-1:2], 2'b00}.

Decomposition:
- Shared package lsu_pkg holds:
  - MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU (3-bit constants matching func3).
  - The state encoding: IDLE=2'd0, BUS=2'd1, WAIT=2'd2, RESP=2'd3.
- One combinational sub-module, lsu_align:
  - Inputs: op, addr[1:0], wdata, bus_rdata.
  - Outputs: wstrb, lane wdata, extended rdata, misalign/illegal flag.
- The FSM and registers stay in lsu_mem_ctrl.

Test Plan:
1. LB at addr 0x103, bus_rdata 0x80FF_1234 (bus_req_ready and rsp zero-wait) -> bus_addr 0x100, bus_wstrb 0000, resp_rdata 0xFFFF_FF80, resp_err 0, resp_valid 3 cycles after accept.
2. LHU at addr 0x202, bus_rdata 0x9ABC_5678 -> resp_rdata 0x0000_9ABC. LH with the same data -> 0xFFFF_9ABC.
3. SB, addr 0x11, wdata 0xDEAD_BEEF -> bus_we 1, bus_addr 0x10, bus_wstrb 0010, bus_wdata 0xEFEF_EFEF. Ack -> resp_valid with rdata 0.
4. SW at addr 0x06 (misaligned) -> resp_valid next cycle with resp_err 1; bus_req_valid never asserted. Load with req_op 011 -> same error response.
5. Backpressure: bus_req_ready low for 3 cycles, then rsp after 2 more -> bus_req_valid and bus_addr held stable, exactly one resp_valid pulse, req_ready 0 throughout.
6. Assert rst in WAIT, then deliver bus_rsp_valid -> no resp_valid. After reset, req_ready = 1 and a new LW at 0x40 returns bus_rdata unchanged.
